// File: rtl/switch_allocator_pkg.sv
// Shared NoC router types: port directions, flit types and allocator FSM states.
package noc_params;

  localparam int unsigned PORT_NUM  = 5;
  localparam int unsigned PORT_SIZE = $clog2(PORT_NUM);

  typedef enum logic [PORT_SIZE-1:0] {LEFT, RIGHT, UP, DOWN, CENTER} port_t;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_type_t;
  typedef enum logic {SA_IDLE, SA_LOCKED} sa_state_t;

  // Round-robin successor of an input index, wrapping PORT_NUM-1 back to 0.
  function automatic logic [PORT_SIZE-1:0] next_port(input logic [PORT_SIZE-1:0] idx);
    return (idx == PORT_SIZE'(PORT_NUM - 1)) ? '0 : idx + PORT_SIZE'(1);
  endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr (circular).
module rr_arbiter #(
  parameter  int unsigned N = 5,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr) + off) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = W'(cand);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin head arbitration with head-to-tail lock.
// Optional per-output forwarded-flit counters enabled by SA_GRANT_COUNT_EN.
module switch_allocator
  import noc_params::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic       [PORT_NUM-1:0]          valid_i,
  input  port_t      [PORT_NUM-1:0]          out_port_i,
  input  flit_type_t [PORT_NUM-1:0]          flit_type_i,
  input  logic       [PORT_NUM-1:0]          out_ready_i,
  output logic       [PORT_NUM-1:0]          grant_o,
  output logic       [PORT_NUM-1:0]          out_valid_o,
  output logic       [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel_o
`ifdef SA_GRANT_COUNT_EN
  ,output logic      [PORT_NUM-1:0][15:0]    grant_cnt_o
`endif
);

  sa_state_t [PORT_NUM-1:0]                state_q, state_d;
  logic      [PORT_NUM-1:0][PORT_SIZE-1:0] owner_q, owner_d;
  logic      [PORT_NUM-1:0][PORT_SIZE-1:0] rr_ptr_q, rr_ptr_d;

  logic [PORT_NUM-1:0][PORT_NUM-1:0]  arb_req;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  arb_grant;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] arb_idx;
  logic [PORT_NUM-1:0]                arb_any;
  logic [PORT_SIZE-1:0]               own;

  // Head-flit requests per output; only these compete while an output is idle.
  always_comb begin
    arb_req = '0;
    for (int unsigned o = 0; o < PORT_NUM; o++) begin
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
        arb_req[o][i] = valid_i[i] && (out_port_i[i] == port_t'(o)) &&
                        ((flit_type_i[i] == HEAD) || (flit_type_i[i] == HEADTAIL));
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
    rr_arbiter #(.N(PORT_NUM)) u_arb (
      .req   (arb_req[o]),
      .ptr   (rr_ptr_q[o]),
      .grant (arb_grant[o]),
      .idx   (arb_idx[o]),
      .any   (arb_any[o])
    );
  end

  // Outputs are gated by reset so they drop the instant rst goes low.
  always_comb begin
    grant_o     = '0;
    out_valid_o = '0;
    xbar_sel_o  = '0;
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    own         = '0;
    if (rst) begin
      for (int unsigned o = 0; o < PORT_NUM; o++) begin
        own = owner_q[o];
        if (state_q[o] == SA_IDLE) begin
          if (out_ready_i[o] && arb_any[o]) begin
            grant_o        = grant_o | arb_grant[o];
            out_valid_o[o] = 1'b1;
            xbar_sel_o[o]  = arb_idx[o];
            if (flit_type_i[arb_idx[o]] == HEAD) begin
              state_d[o] = SA_LOCKED;
              owner_d[o] = arb_idx[o];
            end else begin
              rr_ptr_d[o] = next_port(arb_idx[o]);
            end
          end
        end else if (out_ready_i[o] && valid_i[own] && (out_port_i[own] == port_t'(o)) &&
                     ((flit_type_i[own] == BODY) || (flit_type_i[own] == TAIL))) begin
          grant_o[own]   = 1'b1;
          out_valid_o[o] = 1'b1;
          xbar_sel_o[o]  = own;
          if (flit_type_i[own] == TAIL) begin
            state_d[o]  = SA_IDLE;
            rr_ptr_d[o] = next_port(own);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned o = 0; o < PORT_NUM; o++) state_q[o] <= SA_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef SA_GRANT_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_o <= '0;
    end else begin
      for (int unsigned o = 0; o < PORT_NUM; o++) begin
        if (out_valid_o[o] && (grant_cnt_o[o] != 16'hFFFF))
          grant_cnt_o[o] <= grant_cnt_o[o] + 16'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  for (genvar o = 0; o < PORT_NUM; o++) begin : g_chk_out
    for (genvar i = 0; i < PORT_NUM; i++) begin : g_chk_in
      a_body_from_owner: assert property (@(posedge clk) disable iff (!rst)
        (valid_i[i] && (out_port_i[i] == port_t'(o)) &&
         ((flit_type_i[i] == BODY) || (flit_type_i[i] == TAIL)))
        |-> ((state_q[o] == SA_LOCKED) && (owner_q[o] == PORT_SIZE'(i))));
      a_no_head_in_lock: assert property (@(posedge clk) disable iff (!rst)
        !((state_q[o] == SA_LOCKED) && (owner_q[o] == PORT_SIZE'(i)) && arb_req[o][i]));
    end
  end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator; also covers SA_GRANT_COUNT_EN builds.
module tb_switch_allocator;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst;
  logic       [PORT_NUM-1:0]                valid, out_ready, grant, out_valid;
  port_t      [PORT_NUM-1:0]                out_port;
  flit_type_t [PORT_NUM-1:0]                ftype;
  logic       [PORT_NUM-1:0][PORT_SIZE-1:0] xbar;
`ifdef SA_GRANT_COUNT_EN
  logic       [PORT_NUM-1:0][15:0]          grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid),
    .out_port_i  (out_port),
    .flit_type_i (ftype),
    .out_ready_i (out_ready),
    .grant_o     (grant),
    .out_valid_o (out_valid),
    .xbar_sel_o  (xbar)
`ifdef SA_GRANT_COUNT_EN
    ,.grant_cnt_o (grant_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    valid     = '0;
    out_ready = '1;
    for (int i = 0; i < PORT_NUM; i++) begin
      out_port[i] = LEFT;
      ftype[i]    = HEAD;
    end
  endtask

  task automatic req(input int i, input port_t p, input flit_type_t t);
    valid[i]    = 1'b1;
    out_port[i] = p;
    ftype[i]    = t;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp_grant, input logic [31:0] exp_ovalid);
    @(negedge clk);
    check({tag, "_grant"}, 32'(grant), exp_grant);
    check({tag, "_ovalid"}, 32'(out_valid), exp_ovalid);
  endtask

  int rot_seq [8] = '{2, 3, 0, 1, 2, 3, 0, 1};

  initial begin
    rst = 1'b0;
    clear();
    req(1, CENTER, HEADTAIL);
    req(0, RIGHT, HEAD);
    chk("reset", 32'b0, 32'b0);
    check("reset_xbar", 32'(xbar), 32'd0);
`ifdef SA_GRANT_COUNT_EN
    for (int o = 0; o < PORT_NUM; o++) check("reset_cnt", 32'(grant_cnt[o]), 32'd0);
`endif
    next();
    rst = 1'b1;
    clear();

    // 1) single HEADTAIL, then pointer advanced to UP
    req(1, CENTER, HEADTAIL);
    chk("t1_ht", 32'b00010, 32'b10000);
    check("t1_xbar", 32'(xbar[4]), 32'd1);
    next();
    clear();
    req(0, CENTER, HEADTAIL); req(1, CENTER, HEADTAIL); req(2, CENTER, HEADTAIL);
    chk("t1_ptr_up", 32'b00100, 32'b10000);
    check("t1_ptr_xbar", 32'(xbar[4]), 32'd2);
    next();
    chk("t1_wrap_left", 32'b00001, 32'b10000);
    next();
    chk("t1_right", 32'b00010, 32'b10000);
    check("t1_right_xbar", 32'(xbar[4]), 32'd1);
    next();
    clear();

    // 3) four inputs rotate starting at UP
    for (int i = 0; i < 4; i++) req(i, CENTER, HEADTAIL);
    for (int c = 0; c < 8; c++) begin
      chk("t3_rot", 32'(1 << rot_seq[c]), 32'b10000);
      check("t3_rot_xbar", 32'(xbar[4]), 32'(rot_seq[c]));
      next();
    end
    clear();

    // 2) LEFT packet locks RIGHT; UP head waits
    req(0, RIGHT, HEAD); req(2, RIGHT, HEAD);
    chk("t2_head", 32'b00001, 32'b00010);
    check("t2_head_xbar", 32'(xbar[1]), 32'd0);
    next();
    ftype[0] = BODY;
    chk("t2_body1", 32'b00001, 32'b00010);
    next();
    chk("t2_body2", 32'b00001, 32'b00010);
    next();
    ftype[0] = TAIL;
    chk("t2_tail", 32'b00001, 32'b00010);
    next();
    valid[0] = 1'b0;
    chk("t2_up_head", 32'b00100, 32'b00010);
    check("t2_up_xbar", 32'(xbar[1]), 32'd2);
    next();
    ftype[2] = TAIL;
    chk("t2_up_tail", 32'b00100, 32'b00010);
    next();
    clear();

    // 4) owner bubble holds DOWN for 3 cycles
    req(4, DOWN, HEAD);
    chk("t4_head", 32'b10000, 32'b01000);
    check("t4_head_xbar", 32'(xbar[3]), 32'd4);
    next();
    valid[4] = 1'b0;
    req(0, DOWN, HEAD);
    for (int c = 0; c < 3; c++) begin
      chk("t4_bubble", 32'b0, 32'b0);
      check("t4_bubble_xbar", 32'(xbar[3]), 32'd0);
      next();
    end
    req(4, DOWN, BODY);
    chk("t4_body", 32'b10000, 32'b01000);
    next();
    ftype[4] = TAIL;
    chk("t4_tail", 32'b10000, 32'b01000);
    next();
    valid[4] = 1'b0;
    chk("t4_left_head", 32'b00001, 32'b01000);
    check("t4_left_xbar", 32'(xbar[3]), 32'd0);
    next();
    ftype[0] = TAIL;
    chk("t4_left_tail", 32'b00001, 32'b01000);
    next();
    clear();

    // 5) backpressure on DOWN, then two outputs granted in parallel
    req(1, DOWN, HEADTAIL);
    out_ready[3] = 1'b0;
    chk("t5_stall", 32'b0, 32'b0);
    next();
    out_ready[3] = 1'b1;
    req(0, UP, HEADTAIL);
    chk("t5_go", 32'b00011, 32'b01100);
    check("t5_xbar_down", 32'(xbar[3]), 32'd1);
    check("t5_xbar_up", 32'(xbar[2]), 32'd0);
    next();
    clear();

    // 6) reset mid-packet
    req(2, LEFT, HEAD);
    chk("t6_head", 32'b00100, 32'b00001);
    check("t6_head_xbar", 32'(xbar[0]), 32'd2);
    next();
    ftype[2] = BODY;
    chk("t6_body", 32'b00100, 32'b00001);
`ifdef SA_GRANT_COUNT_EN
    check("t6_cnt_left", 32'(grant_cnt[0]), 32'd1);
    check("t6_cnt_right", 32'(grant_cnt[1]), 32'd6);
    check("t6_cnt_up", 32'(grant_cnt[2]), 32'd1);
    check("t6_cnt_down", 32'(grant_cnt[3]), 32'd6);
    check("t6_cnt_center", 32'(grant_cnt[4]), 32'd12);
`endif
    next();
    rst = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_ovalid", 32'(out_valid), 32'd0);
    check("t6_rst_xbar", 32'(xbar), 32'd0);
`ifdef SA_GRANT_COUNT_EN
    for (int o = 0; o < PORT_NUM; o++) check("t6_rst_cnt", 32'(grant_cnt[o]), 32'd0);
`endif
    clear();
    req(3, LEFT, HEAD);
    chk("t6_in_rst", 32'b0, 32'b0);
    next();
    rst = 1'b1;
    chk("t6_new_head", 32'b01000, 32'b00001);
    check("t6_new_xbar", 32'(xbar[0]), 32'd3);
`ifdef SA_GRANT_COUNT_EN
    check("t6_cnt0", 32'(grant_cnt[0]), 32'd0);
`endif
    next();
    ftype[3] = TAIL;
    chk("t6_new_tail", 32'b01000, 32'b00001);
`ifdef SA_GRANT_COUNT_EN
    check("t6_cnt1", 32'(grant_cnt[0]), 32'd1);
`endif
    next();
    clear();
`ifdef SA_GRANT_COUNT_EN
    check("t6_cnt2", 32'(grant_cnt[0]), 32'd2);
`endif
    chk("t6_idle", 32'b0, 32'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
